prio_encoder_83: RTL
====================

// Module: prio_encoder_83
// PURPOSE
//  Registered 8-to-3 priority encoder with sticky request capture and valid/ready output.
//  Inverse of the team's 3-to-8 active-low decoder: takes 8 active-low request lines and
//  returns the index of the winning request to a downstream consumer.
//  Output pins follow 74x148 conventions (A_n, GS_n, EO_n); code/code_valid carry the handshake.
// PARAMETERS
//  N_REQ        8   number of request lines; fixed at 8 in this revision
//  IDX_W        3   index width, clog2(N_REQ)
//  ROUND_ROBIN  0   0 = fixed priority (I_n[7] highest); 1 = rotating priority after each grant
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  EI_n        in   1      enable in, active-low; gates capture of new requests only
//  I_n         in   8      request lines, active-low, sampled every clk while EI_n=0
//  code_ready  in   1      consumer accepts code on a cycle with code_valid=1
//  code        out  3      winning index, true polarity
//  code_valid  out  1      code is valid; held until accepted
//  A_n         out  3      ~code while code_valid=1; 3'b111 otherwise
//  GS_n        out  1      group select, active-low, equals ~code_valid
//  EO_n        out  1      enable out, active-low: enabled, nothing pending, nothing valid
//  pending     out  8      sticky request register, for debug and status
// BEHAVIOUR
//  - Reset (rst=1 at edge): pending=0, code=0, code_valid=0, A_n=3'b111, GS_n=1, EO_n=1,
//    last_grant=0. Reset takes priority over every other event, including one mid-handshake.
//  - Capture: new_req = ~I_n & {8{~EI_n}}; clr = onehot(code) if (code_valid&&code_ready), else 0.
//    pending_next = (pending & ~clr) | new_req. A line still held low re-asserts its bit after being served.
//  - Select: cand = pending & ~clr. Fixed mode picks the highest set index. RR mode searches
//    downward from last_grant-1, modulo 8. After reset the RR search starts at index 7.
//  - Load: the output register loads when (!code_valid || code_ready) && cand!=0.
//    On load: code<=pick, code_valid<=1, last_grant<=pick.
//    If code_ready=1 and cand==0, then code_valid<=0 and code holds its last value.
//  - Stability: while code_valid=1 && code_ready=0, code, A_n and GS_n must not change.
//  - Latency: I_n low at edge k sets pending at k; code_valid=1 after edge k+1 if the output is free.
//    Back-to-back accepts sustain one code per clk.
//  - A_n and GS_n are registered and updated together with code_valid.
//    EO_n <= ~(~EI_n && pending_next==0 && next code_valid==0).
//  - EI_n=1: capture stops; existing pending bits drain normally; EO_n=1.
//  - All 8 requests asserted together: fixed mode serves 7,6,...,0 in consecutive accepts.
//    RR mode serves 7,6,...,0 and then wraps to 7.
//  - Simultaneous clear and re-assert of the same bit: the set wins, so the bit stays pending.
//    The bit is excluded from cand in that cycle only.
// STRUCTURE
//  - Package enc_pkg: N_REQ, IDX_W, A_N_IDLE=3'b111, RST_LAST_GRANT=0, and the onehot function.
//  - Sub-module prio_pick: combinational. Inputs vec[7:0], start[2:0], rr_en.
//    Outputs idx[2:0], any. Fixed mode ignores start.
//  - Top level holds the pending, output and last_grant registers; there is no FSM beyond code_valid.
// TESTING
//  1 Reset: hold rst with I_n=8'h00 -> all outputs at reset values; after release,
//    code_valid=1 within 2 clk and code=7.
//  2 Fixed priority: pulse I_n=8'b1110_1011 (lines 2 and 4) for 1 clk, code_ready=1
//    -> code=4, then code=2 on consecutive cycles, then code_valid=0 and EO_n=0.
//  3 Backpressure: code_ready=0 with pending 3 and 5 -> code=5 held with A_n=3'b010 stable
//    for 10 clk; raise code_ready -> code=3 on the next cycle.
//  4 Round robin (ROUND_ROBIN=1): I_n held at 8'h00 with ready=1 -> sequence 7,6,5,4,3,2,1,0,7
//    with no gaps.
//  5 Enable: EI_n=1 while pulsing I_n[6] low -> pending stays 0, EO_n=1. Set pending 1, then EI_n=1
//    -> code 1 is still delivered.
//  6 Reset mid-op: rst=1 while code_valid=1, ready=0 -> next clk code_valid=0 and pending=0;
//    I_n held low is re-captured after release.

Source files
------------

// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enc_pkg
//  Description : Shared constants and helpers for the registered 8-to-3
//                priority encoder.
//  Revision    : 1.0  initial release
// ============================================================================
package enc_pkg;

    localparam int               N_REQ          = 8;
    localparam int               IDX_W          = 3;
    localparam logic [IDX_W-1:0] A_N_IDLE       = 3'b111;
    localparam logic [IDX_W-1:0] RST_LAST_GRANT = 3'd0;

    // One-hot mask for a request index, used to clear a served pending bit.
    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v_mask;
        v_mask      = '0;
        v_mask[idx] = 1'b1;
        return v_mask;
    endfunction

endpackage : enc_pkg
`default_nettype wire

// File: rtl/prio_pick.sv
`default_nettype none
// ============================================================================
//  Module      : prio_pick
//  Description : Combinational request picker. Fixed mode returns the highest
//                set index; rotating mode searches downward from start,
//                wrapping modulo N_REQ.
//  Revision    : 1.0  initial release
// ============================================================================
module prio_pick
    import enc_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    input  logic [IDX_W-1:0] start,
    input  logic             rr_en,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] w_pos;
    logic             w_found;

    // Walk the candidates in priority order and keep the first set bit.
    always_comb begin
        idx     = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_pos = rr_en ? IDX_W'(start - IDX_W'(i)) : IDX_W'(N_REQ - 1 - i);
            if (!w_found && vec[w_pos]) begin
                idx     = w_pos;
                w_found = 1'b1;
            end
        end
        any = w_found;
    end

endmodule : prio_pick
`default_nettype wire

// File: rtl/prio_encoder_83.sv
`default_nettype none
// ============================================================================
//  Module      : prio_encoder_83
//  Description : Registered 8-to-3 priority encoder with sticky request
//                capture, valid/ready output and 74x148-style status pins.
//  Revision    : 1.0  initial release
// ============================================================================
module prio_encoder_83
    import enc_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EI_n,
    input  logic [N_REQ-1:0] I_n,
    input  logic             code_ready,
    output logic [IDX_W-1:0] code,
    output logic             code_valid,
    output logic [IDX_W-1:0] A_n,
    output logic             GS_n,
    output logic             EO_n,
    output logic [N_REQ-1:0] pending
);

    logic [N_REQ-1:0] r_pending;
    logic [IDX_W-1:0] r_code;
    logic             r_code_valid;
    logic [IDX_W-1:0] r_a_n;
    logic             r_gs_n;
    logic             r_eo_n;
    logic [IDX_W-1:0] r_last_grant;

    logic [N_REQ-1:0] w_new_req;
    logic [N_REQ-1:0] w_clr;
    logic [N_REQ-1:0] w_cand;
    logic [N_REQ-1:0] w_pending_next;
    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_pick;
    logic             w_any;
    logic             w_load;
    logic [IDX_W-1:0] w_code_next;
    logic             w_valid_next;

    // Request capture and clear of the accepted index; a re-asserted line wins
    // over its own clear but is kept out of this cycle's candidates.
    always_comb begin
        w_new_req      = ~I_n & {N_REQ{~EI_n}};
        w_clr          = (r_code_valid && code_ready) ? onehot(r_code) : '0;
        w_cand         = r_pending & ~w_clr;
        w_pending_next = w_cand | w_new_req;
        w_start        = r_last_grant - 3'd1;
    end

    prio_pick u_pick (
        .vec   (w_cand),
        .start (w_start),
        .rr_en (ROUND_ROBIN),
        .idx   (w_pick),
        .any   (w_any)
    );

    // Output register next state: load when free, drop valid when accepted
    // with nothing left, otherwise hold (code is never changed under stall).
    always_comb begin
        w_load       = (!r_code_valid || code_ready) && w_any;
        w_code_next  = r_code;
        w_valid_next = r_code_valid;
        if (w_load) begin
            w_code_next  = w_pick;
            w_valid_next = 1'b1;
        end else if (code_ready) begin
            w_valid_next = 1'b0;
        end
    end

    // State registers; reset overrides everything including an open handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending    <= '0;
            r_code       <= '0;
            r_code_valid <= 1'b0;
            r_a_n        <= A_N_IDLE;
            r_gs_n       <= 1'b1;
            r_eo_n       <= 1'b1;
            r_last_grant <= RST_LAST_GRANT;
        end else begin
            r_pending    <= w_pending_next;
            r_code       <= w_code_next;
            r_code_valid <= w_valid_next;
            r_a_n        <= w_valid_next ? ~w_code_next : A_N_IDLE;
            r_gs_n       <= ~w_valid_next;
            r_eo_n       <= ~(~EI_n && (w_pending_next == '0) && !w_valid_next);
            if (w_load) begin
                r_last_grant <= w_pick;
            end
        end
    end

    assign code       = r_code;
    assign code_valid = r_code_valid;
    assign A_n        = r_a_n;
    assign GS_n       = r_gs_n;
    assign EO_n       = r_eo_n;
    assign pending    = r_pending;

endmodule : prio_encoder_83
`default_nettype wire
